// File: rtl/bus_arbiter.sv
// Fixed-priority arbiter for the shared 16-bit address / 8-bit data memory bus.
// Holds a grant per transaction, bounds bursts, aborts stalled slaves.
module bus_arbiter #(
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned CNT_W     = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [2:0]  i_req_cs,
    input  logic [2:0]  i_req_we,
    input  logic [47:0] i_req_addr,
    input  logic [23:0] i_req_dat,
    output logic [2:0]  o_req_ack,
    output logic [15:0] o_addr,
    output logic [7:0]  o_dat,
    output logic        o_we,
    output logic        o_cs,
    input  logic        i_ack,
    output logic [2:0]  o_grant,
    output logic        o_busy,
    output logic        o_timeout
);

    typedef enum logic [1:0] {IDLE, OWN, RELEASE} state_e;

    localparam logic [CNT_W:0]   BURST_LIM = (CNT_W+1)'(MAX_BURST);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic [2:0]       mask_q, mask_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             timeout_q, timeout_d;

    logic       cs_sel;
    logic       bus_ack;
    logic       burst_hit;
    logic       timeout_hit;
    logic [2:0] eligible;
    logic [2:0] pick;

    // grant_q is zero outside OWN, so the mux alone forces the bus to 0 when idle.
    always_comb begin
        o_addr = '0;
        o_dat  = '0;
        o_we   = 1'b0;
        cs_sel = 1'b0;
        for (int n = 0; n < 3; n++) begin
            if (grant_q[n]) begin
                o_addr = i_req_addr[16*n +: 16];
                o_dat  = i_req_dat[8*n +: 8];
                o_we   = i_req_we[n];
                cs_sel = i_req_cs[n];
            end
        end
    end

    assign o_cs        = cs_sel & (state_q == OWN);
    assign bus_ack     = o_cs & i_ack;
    assign timeout_hit = (TIMEOUT != 0) && o_cs && !i_ack && (wait_q == WAIT_LAST);
    assign burst_hit   = (MAX_BURST != 0) && bus_ack
                         && (({1'b0, burst_q} + (CNT_W+1)'(1)) >= BURST_LIM)
                         && ((i_req_cs & ~grant_q) != 3'b000);
    assign o_req_ack   = grant_q & {3{bus_ack | timeout_hit}};

    assign eligible = i_req_cs & ~mask_q;
    assign pick     = eligible & (~eligible + 3'd1);

    assign o_grant   = grant_q;
    assign o_busy    = (state_q != IDLE);
    assign o_timeout = timeout_q;

    always_comb begin
        // NOTE: every _d gets a default up front so no path leaves it unassigned (no latches).
        state_d   = state_q;
        grant_d   = grant_q;
        mask_d    = mask_q;
        burst_d   = burst_q;
        wait_d    = wait_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                mask_d = '0;
                if (eligible != 3'b000) begin
                    grant_d = pick;
                    burst_d = '0;
                    wait_d  = '0;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (bus_ack) begin
                    if (burst_q != '1) burst_d = burst_q + CNT_W'(1);
                    wait_d = '0;
                end else if (o_cs) begin
                    wait_d = wait_q + CNT_W'(1);
                end
                if (!cs_sel || burst_hit || timeout_hit) begin
                    state_d = RELEASE;
                    grant_d = '0;
                end
                if (cs_sel && burst_hit) mask_d = grant_q;
                if (cs_sel && !burst_hit && timeout_hit) timeout_d = 1'b1;
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            mask_q    <= '0;
            burst_q   <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            mask_q    <= mask_d;
            burst_q   <= burst_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural ownership model.
module tb_bus_arbiter;

    localparam int MB = 4;
    localparam int TO = 16;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [2:0]  i_req_cs, i_req_we;
    logic [47:0] i_req_addr;
    logic [23:0] i_req_dat;
    logic        i_ack;
    logic [2:0]  o_req_ack, o_grant;
    logic [15:0] o_addr;
    logic [7:0]  o_dat;
    logic        o_we, o_cs, o_busy, o_timeout;

    bus_arbiter #(.MAX_BURST(MB), .TIMEOUT(TO), .CNT_W(8)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_req_cs(i_req_cs), .i_req_we(i_req_we),
        .i_req_addr(i_req_addr), .i_req_dat(i_req_dat), .o_req_ack(o_req_ack),
        .o_addr(o_addr), .o_dat(o_dat), .o_we(o_we), .o_cs(o_cs), .i_ack(i_ack),
        .o_grant(o_grant), .o_busy(o_busy), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: who owns the bus, whether we are in the turnaround gap, and which
    // master sits out the next arbitration after being cut off by the burst limit.
    int   m_owner;
    bit   m_turn;
    int   m_acks;
    int   m_waits;
    int   m_excl;
    bit   m_to;

    logic [2:0]  last_ack, prev_grant, obs_grant, obs_ack;
    logic [15:0] obs_addr;
    logic        obs_cs, obs_to;
    int          grant_log[$];
    int          timeout_seen;

    task automatic model_reset();
        m_owner = -1; m_turn = 0; m_acks = 0; m_waits = 0; m_excl = -1; m_to = 0;
        prev_grant = 3'b000;
    endtask

    task automatic cycle();
        bit          own, tnow, acked, others, new_to;
        logic [2:0]  e_grant, e_ack, elig;
        logic        e_cs, e_we;
        logic [15:0] e_addr;
        logic [7:0]  e_dat;
        #2;
        own     = (m_owner >= 0);
        e_grant = own ? 3'(1 << m_owner) : 3'b000;
        e_cs    = own ? i_req_cs[m_owner] : 1'b0;
        e_we    = own ? i_req_we[m_owner] : 1'b0;
        e_addr  = own ? i_req_addr[16*m_owner +: 16] : 16'h0;
        e_dat   = own ? i_req_dat[8*m_owner +: 8] : 8'h0;
        tnow    = (TO != 0) && e_cs && !i_ack && (m_waits + 1 == TO);
        e_ack   = (e_cs && (i_ack || tnow)) ? e_grant : 3'b000;
        check("grant",   32'(o_grant),   32'(e_grant));
        check("cs",      32'(o_cs),      32'(e_cs));
        check("we",      32'(o_we),      32'(e_we));
        check("addr",    32'(o_addr),    32'(e_addr));
        check("dat",     32'(o_dat),     32'(e_dat));
        check("req_ack", 32'(o_req_ack), 32'(e_ack));
        check("busy",    32'(o_busy),    32'(own || m_turn));
        check("timeout", 32'(o_timeout), 32'(m_to));
        last_ack  = e_ack;
        obs_grant = o_grant; obs_ack = o_req_ack; obs_addr = o_addr;
        obs_cs = o_cs; obs_to = o_timeout;
        if (o_grant != 3'b000 && prev_grant == 3'b000) grant_log.push_back(int'(o_grant));
        prev_grant = o_grant;
        if (o_timeout) timeout_seen++;
        @(posedge i_clk);
        new_to = 0;
        if (m_turn) begin
            m_turn = 0;
        end else if (!own) begin
            elig = i_req_cs & ~((m_excl >= 0) ? 3'(1 << m_excl) : 3'b000);
            m_excl = -1;
            for (int n = 2; n >= 0; n--) if (elig[n]) m_owner = n;
            m_acks = 0; m_waits = 0;
        end else begin
            acked  = e_cs && i_ack;
            others = (i_req_cs & ~e_grant) != 3'b000;
            if (acked) begin m_acks++; m_waits = 0; end
            else if (e_cs) m_waits++;
            if (!e_cs) begin
                m_owner = -1; m_turn = 1;
            end else if (MB != 0 && acked && m_acks >= MB && others) begin
                m_excl = m_owner; m_owner = -1; m_turn = 1;
            end else if (tnow) begin
                new_to = 1; m_owner = -1; m_turn = 1;
            end
        end
        m_to = new_to;
        #1;
    endtask

    task automatic idle_inputs(input int n);
        i_req_cs = 3'b000; i_ack = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic reset_mid();
        #3;
        i_reset = 1'b1;
        #1;
        check("rst_cs",    32'(o_cs),      32'd0);
        check("rst_grant", 32'(o_grant),   32'd0);
        check("rst_ack",   32'(o_req_ack), 32'd0);
        check("rst_busy",  32'(o_busy),    32'd0);
        model_reset();
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
    endtask

    initial begin
        int rem[3];
        int cs_idx, to_idx, ack_cnt;

        i_reset = 1'b1; i_req_cs = '0; i_req_we = '0; i_req_addr = '0; i_req_dat = '0; i_ack = 1'b0;
        timeout_seen = 0;
        model_reset();
        #3;
        check("init_grant", 32'(o_grant),   32'd0);
        check("init_cs",    32'(o_cs),      32'd0);
        check("init_addr",  32'(o_addr),    32'd0);
        check("init_ack",   32'(o_req_ack), 32'd0);
        check("init_to",    32'(o_timeout), 32'd0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;

        // Single requester: master 2 reads 0x1234, slave acks on the third bus cycle.
        i_req_addr = {16'h1234, 16'hAAAA, 16'h5555};
        i_req_we = 3'b000; i_req_cs = 3'b100; ack_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            i_ack = (k == 3);
            if (k == 5) i_req_cs = 3'b000;
            cycle();
            if (k == 1) begin
                check("single_grant", 32'(obs_grant), 32'h4);
                check("single_addr",  32'(obs_addr),  32'h1234);
            end
            if (obs_ack[2]) ack_cnt++;
        end
        check("single_acks", 32'(ack_cnt), 32'd1);
        idle_inputs(3);

        // Fixed priority: all three request together, each takes two acks and leaves.
        grant_log.delete();
        i_req_dat = {8'hC2, 8'hB1, 8'hA0}; i_req_we = 3'b011;
        i_req_cs = 3'b111; i_ack = 1'b1; rem = '{2, 2, 2};
        for (int k = 0; k < 20; k++) begin
            cycle();
            for (int n = 0; n < 3; n++)
                if (last_ack[n]) begin
                    rem[n]--;
                    if (rem[n] == 0) i_req_cs[n] = 1'b0;
                end
        end
        check("prio_count", 32'(grant_log.size()), 32'd3);
        if (grant_log.size() >= 3) begin
            check("prio_first",  32'(grant_log[0]), 32'd1);
            check("prio_second", 32'(grant_log[1]), 32'd2);
            check("prio_third",  32'(grant_log[2]), 32'd4);
        end
        idle_inputs(3);

        // Burst limit: masters 0 and 2 both stream with an ack every cycle.
        grant_log.delete();
        i_req_cs = 3'b101; i_ack = 1'b1;
        for (int k = 0; k < 16; k++) cycle();
        check("burst_count", 32'(grant_log.size() >= 3), 32'd1);
        if (grant_log.size() >= 3) begin
            check("burst_first",  32'(grant_log[0]), 32'd1);
            check("burst_second", 32'(grant_log[1]), 32'd4);
            check("burst_third",  32'(grant_log[2]), 32'd1);
        end
        idle_inputs(3);

        // Timeout: master 1 never gets an ack.
        timeout_seen = 0; cs_idx = -1; to_idx = -1;
        i_req_cs = 3'b010; i_ack = 1'b0;
        for (int k = 0; k < 24; k++) begin
            cycle();
            if (obs_cs && cs_idx < 0) cs_idx = k;
            if (obs_to && to_idx < 0) to_idx = k;
            if (cs_idx >= 0 && k == cs_idx + 15) check("to_forced_ack", 32'(obs_ack), 32'h2);
            if (k == 17) i_req_cs = 3'b000;
        end
        check("to_delay", 32'(to_idx - cs_idx), 32'd16);
        check("to_pulses", 32'(timeout_seen), 32'd1);
        idle_inputs(3);

        // Ack arriving in the very cycle the timeout would fire.
        timeout_seen = 0; ack_cnt = 0;
        i_req_cs = 3'b010;
        for (int k = 0; k < 20; k++) begin
            i_ack = (k == 16);
            if (k == 17) i_req_cs = 3'b000;
            cycle();
            if (obs_ack[1]) ack_cnt++;
        end
        check("coinc_no_timeout", 32'(timeout_seen), 32'd0);
        check("coinc_acks",       32'(ack_cnt),      32'd1);
        idle_inputs(3);

        // Random traffic with sticky requests.
        i_req_cs = 3'b000;
        for (int k = 0; k < 2500; k++) begin
            for (int n = 0; n < 3; n++)
                if ($urandom_range(7) == 0) i_req_cs[n] = ~i_req_cs[n];
            i_req_we   = 3'($urandom);
            i_req_addr = {16'($urandom), 16'($urandom), 16'($urandom)};
            i_req_dat  = 24'($urandom);
            i_ack      = ($urandom_range(3) == 0);
            cycle();
        end
        idle_inputs(4);

        // Asynchronous reset while master 0 is mid-burst.
        i_req_cs = 3'b001; i_ack = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        reset_mid();
        cycle();
        cycle();
        check("rst_regrant", 32'(obs_grant), 32'h1);
        idle_inputs(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
